// File: rtl/pgm_rx_chk.sv
// pgm_rx_chk: receive-side packet checker with in-band config access.
// Optional latency statistics are built when PGM_RX_LAT_EN is defined.
module pgm_rx_chk #(
   parameter logic [7:0] LMID      = 8'd63,
   parameter logic [2:0] STAMP_IDX = 3'd4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [133:0] in_data,
   input  logic         in_data_wr,
   input  logic         in_valid,
   input  logic         in_valid_wr,
   output logic [133:0] out_data,
   output logic         out_data_wr,
   output logic         out_valid,
   output logic         out_valid_wr,
   input  logic         in_alf,
   output logic         out_alf,
   input  logic [31:0]  ts_now,
   input  logic [133:0] cin_data,
   input  logic         cin_data_wr,
   output logic         cout_ready,
   output logic [133:0] cout_data,
   output logic         cout_data_wr,
   input  logic         cin_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BODY = 2'd1,
      EVAL = 2'd2
   } state_t;

   localparam logic [31:0] A_CTRL   = 32'h0002_0000;
   localparam logic [31:0] A_PKT_LO = 32'h0002_0001;
   localparam logic [31:0] A_PKT_HI = 32'h0002_0002;
   localparam logic [31:0] A_BYT_LO = 32'h0002_0003;
   localparam logic [31:0] A_BYT_HI = 32'h0002_0004;
   localparam logic [31:0] A_LOST   = 32'h0002_0005;
   localparam logic [31:0] A_OOO    = 32'h0002_0006;
   localparam logic [31:0] A_LAT_L  = 32'h0002_0007;
   localparam logic [31:0] A_LAT_MN = 32'h0002_0008;
   localparam logic [31:0] A_LAT_MX = 32'h0002_0009;
   localparam logic [31:0] A_LAT_SL = 32'h0002_000A;
   localparam logic [31:0] A_LAT_SH = 32'h0002_000B;
   localparam logic [31:0] A_STATE  = 32'h1111_1111;

   state_t state;
   state_t state_nx;

   logic [1:0]  in_hdr;
   logic        in_head;
   logic        in_tail;
   logic        marker_ok;
   logic [31:0] tail_b;

   logic [15:0] widx;
   logic [15:0] widx_inc;
   logic        at_stamp;
   logic [31:0] pkt_bytes;
   logic        stamp_hit;
   logic [63:0] st_seq;

   logic        enable;
   logic        clr;
   logic        seq_init;
   logic [63:0] exp_seq;
   logic [63:0] rx_pkt;
   logic [63:0] rx_byte;
   logic [31:0] lost_cnt;
   logic [31:0] ooo_cnt;
   logic [63:0] seq_gap;
   logic [64:0] lost_sum;
   logic [31:0] lost_nx;

   logic [1:0]  cin_hdr;
   logic        cin_head;
   logic        cin_tail;
   logic        cfg_hit;
   logic        cfg_wr;
   logic        cfg_rd;
   logic [31:0] cfg_addr;
   logic        sup_tail;
   logic [31:0] rd_val;
   logic [133:0] rd_word;

`ifdef PGM_RX_LAT_EN
   logic [31:0] st_ts;
   logic [31:0] lat;
   logic [31:0] lat_last;
   logic [31:0] lat_min;
   logic [31:0] lat_max;
   logic [63:0] lat_sum;
`else
   logic        unused_ts;
   assign unused_ts = ^ts_now;
`endif

   assign out_alf    = in_alf;
   assign cout_ready = cin_ready;

   assign in_hdr    = in_data[133:132];
   assign in_head   = in_data_wr && (in_hdr == 2'b01);
   assign in_tail   = in_data_wr && (in_hdr == 2'b10);
   assign marker_ok = (in_data[31:0] == 32'hFFFF_FFFF);
   assign tail_b    = (in_data[131:128] == 4'd0) ?
                      32'd16 : {28'd0, in_data[131:128]};
   assign widx_inc  = (widx == 16'hFFFF) ? widx : widx + 16'd1;
   assign at_stamp  = (widx == {13'd0, STAMP_IDX});

   assign seq_gap  = st_seq - exp_seq;
   assign lost_sum = {33'd0, lost_cnt} + {1'b0, seq_gap};
   assign lost_nx  = (lost_sum[64:32] != 33'd0) ?
                     32'hFFFF_FFFF : lost_sum[31:0];

`ifdef PGM_RX_LAT_EN
   assign lat = ts_now - st_ts;
`endif

   assign cin_hdr  = cin_data[133:132];
   assign cin_head = cin_data_wr && (cin_hdr == 2'b01);
   assign cin_tail = cin_data_wr && (cin_hdr == 2'b10);
   assign cfg_hit  = cin_head && (cin_data[103:96] == LMID);
   assign cfg_wr   = cfg_hit && (cin_data[126:124] == 3'b010);
   assign cfg_rd   = cfg_hit && (cin_data[126:124] == 3'b001);
   assign cfg_addr = cin_data[95:64];
   assign clr      = cfg_wr && (cfg_addr == A_CTRL) && cin_data[0];

   // Pass-through of the receive stream, one cycle late.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data     <= '0;
         out_data_wr  <= 1'b0;
         out_valid    <= 1'b0;
         out_valid_wr <= 1'b0;
      end else begin
         out_data     <= in_data;
         out_data_wr  <= in_data_wr;
         out_valid    <= in_valid;
         out_valid_wr <= in_valid_wr;
      end
   end

   // Packet tracking state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state: a head in BODY restarts the packet in place.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_head) state_nx = BODY;
         BODY:    if (in_tail) state_nx = EVAL;
         EVAL:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Word index, byte length and stamp capture of the current packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widx      <= '0;
         pkt_bytes <= '0;
         stamp_hit <= 1'b0;
         st_seq    <= '0;
`ifdef PGM_RX_LAT_EN
         st_ts     <= '0;
`endif
      end else if (in_head && (state != EVAL)) begin
         widx      <= 16'd1;
         pkt_bytes <= 32'd16;
         stamp_hit <= (STAMP_IDX == 3'd0) && marker_ok;
         st_seq    <= in_data[127:64];
`ifdef PGM_RX_LAT_EN
         st_ts     <= in_data[63:32];
`endif
      end else if ((state == BODY) && in_data_wr) begin
         widx      <= widx_inc;
         pkt_bytes <= pkt_bytes + (in_tail ? tail_b : 32'd16);
         if (at_stamp && marker_ok) begin
            stamp_hit <= 1'b1;
            st_seq    <= in_data[127:64];
`ifdef PGM_RX_LAT_EN
            st_ts     <= in_data[63:32];
`endif
         end
      end
   end

   // Control register: enable bit, written by config packets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable <= 1'b1;
      end else if (cfg_wr && (cfg_addr == A_CTRL)) begin
         enable <= cin_data[1];
      end
   end

   // Statistics update at end of packet; clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_pkt   <= '0;
         rx_byte  <= '0;
         lost_cnt <= '0;
         ooo_cnt  <= '0;
         exp_seq  <= '0;
         seq_init <= 1'b0;
`ifdef PGM_RX_LAT_EN
         lat_last <= '0;
         lat_min  <= 32'hFFFF_FFFF;
         lat_max  <= '0;
         lat_sum  <= '0;
`endif
      end else if (clr) begin
         rx_pkt   <= '0;
         rx_byte  <= '0;
         lost_cnt <= '0;
         ooo_cnt  <= '0;
         exp_seq  <= '0;
         seq_init <= 1'b0;
`ifdef PGM_RX_LAT_EN
         lat_last <= '0;
         lat_min  <= 32'hFFFF_FFFF;
         lat_max  <= '0;
         lat_sum  <= '0;
`endif
      end else if ((state == EVAL) && enable) begin
         rx_pkt  <= rx_pkt + 64'd1;
         rx_byte <= rx_byte + {32'd0, pkt_bytes};
         if (stamp_hit) begin
            if (!seq_init) begin
               seq_init <= 1'b1;
               exp_seq  <= st_seq + 64'd1;
            end else if (st_seq > exp_seq) begin
               lost_cnt <= lost_nx;
               exp_seq  <= st_seq + 64'd1;
            end else if (st_seq == exp_seq) begin
               exp_seq  <= st_seq + 64'd1;
            end else begin
               ooo_cnt  <= ooo_cnt + 32'd1;
            end
`ifdef PGM_RX_LAT_EN
            lat_last <= lat;
            lat_sum  <= lat_sum + {32'd0, lat};
            if (lat < lat_min) lat_min <= lat;
            if (lat > lat_max) lat_max <= lat;
`endif
         end
      end
   end

   // Register read mux for config reads.
   always_comb begin
      rd_val = 32'hFFFF_FFFF;
      case (cfg_addr)
         A_CTRL:   rd_val = {30'd0, enable, 1'b0};
         A_PKT_LO: rd_val = rx_pkt[31:0];
         A_PKT_HI: rd_val = rx_pkt[63:32];
         A_BYT_LO: rd_val = rx_byte[31:0];
         A_BYT_HI: rd_val = rx_byte[63:32];
         A_LOST:   rd_val = lost_cnt;
         A_OOO:    rd_val = ooo_cnt;
`ifdef PGM_RX_LAT_EN
         A_LAT_L:  rd_val = lat_last;
         A_LAT_MN: rd_val = lat_min;
         A_LAT_MX: rd_val = lat_max;
         A_LAT_SL: rd_val = lat_sum[31:0];
         A_LAT_SH: rd_val = lat_sum[63:32];
`else
         A_LAT_L:  rd_val = 32'd0;
         A_LAT_MN: rd_val = 32'd0;
         A_LAT_MX: rd_val = 32'd0;
         A_LAT_SL: rd_val = 32'd0;
         A_LAT_SH: rd_val = 32'd0;
`endif
         A_STATE:  rd_val = {30'd0, state};
         default:  rd_val = 32'hFFFF_FFFF;
      endcase
   end

   // Read response: marked as reply, src/dst ids swapped.
   assign rd_word = {cin_data[133:128], 4'b1011,
                     cin_data[123:112],
                     cin_data[103:96], cin_data[111:104],
                     cin_data[95:32], rd_val};

   // Remembers that the tail of a write packet must be dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           sup_tail <= 1'b0;
      else if (cfg_wr)   sup_tail <= 1'b1;
      else if (cin_tail) sup_tail <= 1'b0;
   end

   // Config channel output, one cycle late.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cout_data    <= '0;
         cout_data_wr <= 1'b0;
      end else begin
         cout_data    <= cfg_rd ? rd_word : cin_data;
         cout_data_wr <= cin_data_wr && !cfg_wr &&
                         !(sup_tail && cin_tail);
      end
   end

endmodule

// File: tb/tb_pgm_rx_chk.sv
// tb_pgm_rx_chk: directed self-checking bench for pgm_rx_chk.
// Latency checks follow PGM_RX_LAT_EN when it is defined.
module tb_pgm_rx_chk;

   localparam logic [7:0]  LMID   = 8'd63;
   localparam int          STAMP  = 4;
   localparam logic [31:0] A_CTRL = 32'h0002_0000;
   localparam logic [31:0] A_PKTL = 32'h0002_0001;
   localparam logic [31:0] A_PKTH = 32'h0002_0002;
   localparam logic [31:0] A_BYTL = 32'h0002_0003;
   localparam logic [31:0] A_LOST = 32'h0002_0005;
   localparam logic [31:0] A_OOO  = 32'h0002_0006;
   localparam logic [31:0] A_LATL = 32'h0002_0007;
   localparam logic [31:0] A_LATN = 32'h0002_0008;
   localparam logic [31:0] A_LATX = 32'h0002_0009;
   localparam logic [31:0] A_LATS = 32'h0002_000A;
   localparam logic [31:0] A_ST   = 32'h1111_1111;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [133:0] in_data = '0;
   logic         in_data_wr = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_valid_wr = 1'b0;
   logic [133:0] out_data;
   logic         out_data_wr;
   logic         out_valid;
   logic         out_valid_wr;
   logic         in_alf = 1'b0;
   logic         out_alf;
   logic [31:0]  ts_now = '0;
   logic [133:0] cin_data = '0;
   logic         cin_data_wr = 1'b0;
   logic         cout_ready;
   logic [133:0] cout_data;
   logic         cout_data_wr;
   logic         cin_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [133:0] cw_head;
   logic [133:0] cw_tail;
   logic         cw_hwr;
   logic         cw_twr;
   logic [31:0]  v;
   logic [133:0] hw;

   pgm_rx_chk #(.LMID(LMID), .STAMP_IDX(3'd4)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_data_wr(in_data_wr),
      .in_valid(in_valid), .in_valid_wr(in_valid_wr),
      .out_data(out_data), .out_data_wr(out_data_wr),
      .out_valid(out_valid), .out_valid_wr(out_valid_wr),
      .in_alf(in_alf), .out_alf(out_alf),
      .ts_now(ts_now),
      .cin_data(cin_data), .cin_data_wr(cin_data_wr),
      .cout_ready(cout_ready),
      .cout_data(cout_data), .cout_data_wr(cout_data_wr),
      .cin_ready(cin_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one word at a negedge; check pass-through one edge later.
   task automatic word(input logic [1:0] hdr, input logic [3:0] nib,
                       input logic [127:0] pl);
      logic [133:0] w;
      w = {hdr, nib, pl};
      in_data = w;
      in_data_wr = 1'b1;
      in_valid = (hdr == 2'b10);
      in_valid_wr = (hdr == 2'b10);
      @(negedge clk);
      chk("pass", {23'd0, out_data, out_data_wr, out_valid, out_valid_wr},
          {23'd0, w, 1'b1, hdr == 2'b10, hdr == 2'b10});
   endtask

   task automatic idle(input int n);
      in_data_wr = 1'b0;
      in_valid = 1'b0;
      in_valid_wr = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [127:0] pay(input int i, input logic [63:0] seq,
                                        input logic [31:0] ts, input logic good);
      if (i == STAMP)
         return {seq, ts, good ? 32'hFFFF_FFFF : 32'h1234_5678};
      return {32'(i), 96'hA5A5_0000_0000_0000_0000_5A5A};
   endfunction

   task automatic pkt(input int n, input logic [63:0] seq, input logic [31:0] ts,
                      input logic good, input logic [3:0] nib);
      for (int i = 0; i < n; i++) begin
         if (i == 0)          word(2'b01, 4'h0, pay(i, seq, ts, good));
         else if (i == n - 1) word(2'b10, nib, pay(i, seq, ts, good));
         else                 word(2'b11, 4'h0, pay(i, seq, ts, good));
      end
      idle(2);
   endtask

   task automatic partial(input int n, input logic [63:0] seq);
      for (int i = 0; i < n; i++)
         word(i == 0 ? 2'b01 : 2'b11, 4'h0, pay(i, seq, 32'h0, 1'b1));
   endtask

   task automatic cfg(input logic [2:0] op, input logic [31:0] addr,
                      input logic [7:0] dst, input logic [31:0] val);
      cin_data = {2'b01, 4'h0, 1'b0, op, 12'h0, 8'h05, dst,
                  addr, 32'h0, val};
      cin_data_wr = 1'b1;
      @(negedge clk);
      cw_head = cout_data;
      cw_hwr = cout_data_wr;
      cin_data = {2'b10, 4'h0, 128'hC0DE};
      @(negedge clk);
      cw_tail = cout_data;
      cw_twr = cout_data_wr;
      cin_data_wr = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] val);
      cfg(3'b001, addr, LMID, 32'h0);
      val = cw_head[31:0];
   endtask

   task automatic rchk(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp);
      logic [31:0] r;
      rd(addr, r);
      chk(tag, {128'd0, r}, {128'd0, exp});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out", {25'd0, out_data, out_data_wr, cout_data_wr},
          160'd0);
      chk("rst_cout", {26'd0, cout_data}, 160'd0);
      rst = 1'b0;
      @(negedge clk);

      in_alf = 1'b1;
      cin_ready = 1'b1;
      #1;
      chk("alf_hi", {158'd0, out_alf, cout_ready}, 160'd3);
      in_alf = 1'b0;
      cin_ready = 1'b0;
      #1;
      chk("alf_lo", {158'd0, out_alf, cout_ready}, 160'd0);
      @(negedge clk);

      rchk("ctrl_rst", A_CTRL, 32'h2);
      rchk("state_rst", A_ST, 32'h0);
      rchk("pkt_rst", A_PKTL, 32'h0);
      rchk("bad_addr", 32'h0002_0010, 32'hFFFF_FFFF);
`ifdef PGM_RX_LAT_EN
      rchk("latmin_rst", A_LATN, 32'hFFFF_FFFF);
`else
      rchk("latmin_off", A_LATN, 32'h0);
`endif

      for (int s = 0; s < 5; s++)
         pkt(6, 64'(s), 32'h0, 1'b1, 4'h4);
      rchk("pkt5", A_PKTL, 32'd5);
      rchk("pkt5_hi", A_PKTH, 32'd0);
      rchk("byte420", A_BYTL, 32'd420);
      rchk("lost0", A_LOST, 32'd0);
      rchk("ooo0", A_OOO, 32'd0);

      cfg(3'b010, A_CTRL, LMID, 32'h3);
      rchk("clr_pkt", A_PKTL, 32'd0);
      pkt(6, 64'd0, 32'h0, 1'b1, 4'h4);
      pkt(6, 64'd1, 32'h0, 1'b1, 4'h4);
      pkt(6, 64'd5, 32'h0, 1'b1, 4'h4);
      rchk("lost3", A_LOST, 32'd3);
      pkt(6, 64'd3, 32'h0, 1'b1, 4'h4);
      rchk("ooo1", A_OOO, 32'd1);
      rchk("lost3b", A_LOST, 32'd3);
      pkt(6, 64'd6, 32'h0, 1'b1, 4'h4);
      rchk("exp6", A_LOST, 32'd3);
      pkt(6, 64'd8, 32'h0, 1'b1, 4'h4);
      rchk("lost4", A_LOST, 32'd4);
      pkt(6, 64'd100, 32'h0, 1'b0, 4'h4);
      pkt(3, 64'd200, 32'h0, 1'b1, 4'h0);
      rchk("pkt8", A_PKTL, 32'd8);
      rchk("byte636", A_BYTL, 32'd636);
      rchk("lost4b", A_LOST, 32'd4);
      rchk("ooo1b", A_OOO, 32'd1);

      cfg(3'b010, A_CTRL, LMID, 32'h3);
      pkt(3, 64'd0, 32'h0, 1'b1, 4'h4);
      partial(5, 64'd50);
      pkt(6, 64'd10, 32'h0, 1'b1, 4'h4);
      rchk("abort_pkt2", A_PKTL, 32'd2);
      rchk("abort_byte", A_BYTL, 32'd120);
      pkt(6, 64'd11, 32'h0, 1'b1, 4'h4);
      rchk("abort_lost", A_LOST, 32'd0);
      rchk("abort_ooo", A_OOO, 32'd0);
      partial(5, 64'd90);
      pkt(3, 64'd0, 32'h0, 1'b1, 4'h4);
      pkt(6, 64'd12, 32'h0, 1'b1, 4'h4);
      rchk("abort2_pkt", A_PKTL, 32'd5);
      rchk("abort2_lost", A_LOST, 32'd0);
      rchk("abort2_ooo", A_OOO, 32'd0);

      cfg(3'b010, A_CTRL, LMID, 32'h3);
      pkt(6, 64'd0, 32'h0, 1'b1, 4'h4);
      pkt(6, 64'h1_0000_0000, 32'h0, 1'b1, 4'h4);
      rchk("lost_sat", A_LOST, 32'hFFFF_FFFF);
      pkt(6, 64'h1_0000_0005, 32'h0, 1'b1, 4'h4);
      rchk("lost_sat2", A_LOST, 32'hFFFF_FFFF);

      cfg(3'b010, A_CTRL, LMID, 32'h0);
      pkt(6, 64'h1_0000_0009, 32'h0, 1'b1, 4'h4);
      rchk("frozen_pkt", A_PKTL, 32'd3);
      rchk("ctrl_dis", A_CTRL, 32'h0);

      cfg(3'b001, A_LOST, LMID, 32'h0);
      hw = {2'b01, 4'h0, 4'hB, 12'h0, 8'h3F, 8'h05,
            A_LOST, 32'h0, 32'hFFFF_FFFF};
      chk("rd_head", {26'd0, cw_head}, {26'd0, hw});
      chk("rd_hwr", {159'd0, cw_hwr}, 160'd1);
      chk("rd_tail", {25'd0, cw_tail, cw_twr},
          {25'd0, 2'b10, 4'h0, 128'hC0DE, 1'b1});

      cfg(3'b010, A_CTRL, LMID, 32'h1);
      chk("wr_sup", {158'd0, cw_hwr, cw_twr}, 160'd0);
      rchk("wr_clr_pkt", A_PKTL, 32'd0);
      rchk("wr_clr_lost", A_LOST, 32'd0);
      cfg(3'b010, A_CTRL, LMID, 32'h2);

      cfg(3'b010, A_CTRL, 8'h40, 32'h1);
      hw = {2'b01, 4'h0, 4'h2, 12'h0, 8'h05, 8'h40,
            A_CTRL, 32'h0, 32'h1};
      chk("other_id", {25'd0, cw_head, cw_hwr}, {25'd0, hw, 1'b1});
      rchk("other_ctrl", A_CTRL, 32'h2);

`ifdef PGM_RX_LAT_EN
      cfg(3'b010, A_CTRL, LMID, 32'h3);
      ts_now = 32'h0000_0010;
      pkt(6, 64'd0, 32'hFFFF_FFF0, 1'b1, 4'h4);
      rchk("lat_last", A_LATL, 32'h20);
      rchk("lat_min", A_LATN, 32'h20);
      rchk("lat_max", A_LATX, 32'h20);
      ts_now = 32'h0000_0040;
      pkt(6, 64'd1, 32'h0000_0010, 1'b1, 4'h4);
      rchk("lat_min2", A_LATN, 32'h20);
      rchk("lat_max2", A_LATX, 32'h30);
      rchk("lat_sum", A_LATS, 32'h50);
`else
      rchk("lat_off", A_LATL, 32'h0);
`endif

      pkt(6, 64'd7, 32'h0, 1'b1, 4'h4);
      word(2'b01, 4'h0, pay(0, 64'd0, 32'h0, 1'b1));
      word(2'b11, 4'h0, pay(1, 64'd0, 32'h0, 1'b1));
      rchk("mid_state", A_ST, 32'h1);
      rst = 1'b1;
      idle(1);
      chk("mid_rst", {24'd0, out_data, out_data_wr, out_valid,
                      out_valid_wr, cout_data_wr}, 160'd0);
      rst = 1'b0;
      word(2'b10, 4'h4, pay(5, 64'd0, 32'h0, 1'b1));
      idle(2);
      rchk("mid_st0", A_ST, 32'h0);
      rchk("mid_pkt0", A_PKTL, 32'd0);
      rchk("mid_ctrl", A_CTRL, 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pgm_rx_chk.md
PGM_RX_CHK -- requirements
Module: pgm_rx_chk

Interface
REQ-001 Parameter LMID, 8'd63, own module ID matched against config packet bits [103:96].
REQ-002 Parameter STAMP_IDX, 3'd4, zero-based word index of the stamp word within a data packet (word 0 = header word, hdr 2'b01).
REQ-003 Port clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Ports in_data/in_data_wr/in_valid/in_valid_wr  in  134/1/1/1  received packet words; [133:132] 01 head, 11 body, 10 tail; [131:128] tail byte count.
REQ-006 Ports out_data/out_data_wr/out_valid/out_valid_wr  out  134/1/1/1  pass-through of in_* delayed one cycle, unmodified.
REQ-007 Ports in_alf in 1, out_alf out 1  backpressure; out_alf = in_alf combinationally.
REQ-008 Port ts_now  in  32  free-running receive timestamp.
REQ-009 Ports cin_data/cin_data_wr in 134/1, cout_ready out 1; cout_data/cout_data_wr out 134/1, cin_ready in 1; cout_ready = cin_ready.

Function
REQ-010 Stamp word layout SHALL be: [127:64] 64-bit sequence, [63:32] tx timestamp, [31:0] marker 32'hFFFFFFFF; stamp valid only if marker matches.
REQ-011 FSM SHALL have states IDLE, BODY, EVAL; IDLE->BODY on head word; BODY->EVAL on tail word; EVAL->IDLE unconditionally after one cycle.
REQ-012 A head word in BODY SHALL abort the current packet (no stats update) and restart word indexing at 0, remaining in BODY.
REQ-013 Byte count SHALL add 16 per head/body word and [131:128] for the tail word, with 4'd0 meaning 16.
REQ-014 In EVAL, if enabled: rx_pkt_cnt(64) += 1, rx_byte_cnt(64) += packet bytes; both wrap modulo 2^64.
REQ-015 Packets shorter than STAMP_IDX+1 words or with a bad marker SHALL update only rx_pkt_cnt and rx_byte_cnt.
REQ-016 First stamped packet after reset or clear SHALL set exp_seq = seq+1 with no loss or out-of-order (ooo) accounting.
REQ-017 Subsequent stamped packets: seq > exp_seq → lost_cnt += seq-exp_seq, saturating at 32'hFFFFFFFF, then exp_seq = seq+1; seq == exp_seq → exp_seq = seq+1; seq < exp_seq → ooo_cnt(32) += 1 and exp_seq is unchanged.
REQ-018 Config write: cin head word with [103:96]==LMID and [126:124]==3'b010 SHALL update the register at [95:64] from [31:0]; both head and tail words of that packet SHALL be suppressed (cout_data_wr=0).
REQ-019 Config read: [126:124]==3'b001 SHALL emit the head word with [127:124]=4'b1011, [111:104] and [103:96] swapped, [31:0]=register value, all other bits copied; the tail word passes through.
REQ-020 All other cin words SHALL pass to cout with one-cycle latency, unchanged.
REQ-021 Register map: 0x00020000 ctrl (bit0 clear pulse, bit1 enable, reset 1); 0x00020001/2 rx_pkt lo/hi; 0x00020003/4 rx_byte lo/hi; 0x00020005 lost; 0x00020006 ooo; 0x00020007 lat_last; 0x00020008 lat_min; 0x00020009 lat_max; 0x0002000A/B lat_sum lo/hi; 0x11111111 FSM state in [1:0]; any other address reads 32'hFFFFFFFF.
REQ-022 Clear SHALL zero all statistics, set lat_min=32'hFFFFFFFF and return the first-packet flag of REQ-016 to unset; clear coincident with EVAL SHALL win.
REQ-023 enable=0 SHALL freeze all statistics while pass-through and the FSM continue.

Reset
REQ-024 rst SHALL force IDLE, all out_*/cout_* outputs to 0, all statistics to 0, lat_min to 32'hFFFFFFFF and enable to 1, including mid-packet; that packet is never counted.

Configuration
REQ-025 Macro PGM_RX_LAT_EN defined: in EVAL for stamped packets, lat = ts_now - tx_ts modulo 2^32; update lat_last, lat_min, lat_max, lat_sum(64).
REQ-026 PGM_RX_LAT_EN undefined: no latency logic; lat_* registers read 0 and ts_now is unused.

Verification
REQ-027 Six-word packet, seq=0..4, tail nibble 4'h4 → rx_pkt=5, rx_byte=5*84=420, lost=0, ooo=0; out_* equals in_* delayed one cycle.
REQ-028 Seq 0,1,5 → lost=3; then seq 3 → ooo=1, exp_seq stays 6.
REQ-029 With PGM_RX_LAT_EN, tx_ts=32'hFFFFFFF0 and ts_now=32'h00000010 → lat_last=0x20, lat_min=lat_max=0x20.
REQ-030 Three-word packet, then a head word at word 3 followed by a full stamped packet → rx_pkt=2, and only the second packet's stamp is used.
REQ-031 Config read of 0x00020005 with [111:104]=8'h05, [103:96]=8'h3F → [127:124]=4'hB, [111:104]=8'h3F, [103:96]=8'h05, [31:0]=lost; write of 0x00020000=1 → stats cleared, cout_data_wr stays 0 for both words.
REQ-032 rst asserted during BODY → all outputs 0 next edge, FSM IDLE, rx_pkt=0.
